// File: rtl/hazard_pkg.sv
// Shared types for the forwarding/hazard unit: select encoding, tracking-entry
// layout and the zero-register constant.
package hazard_pkg;

  localparam logic [4:0] XZR = 5'd31;

  // Entries store register addresses zero-extended to this width, so any
  // REG_ADDR_W up to ENTRY_AW fits the shared struct.
  localparam int ENTRY_AW = 8;

  typedef enum logic [1:0] {
    FWD_EXE = 2'b00,
    FWD_MEM = 2'b01,
    FWD_RF  = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [ENTRY_AW-1:0] aw;
    logic                regwrite;
    logic                is_load;
  } stage_entry_t;

  localparam stage_entry_t BUBBLE = '0;

  function automatic logic entry_live(input stage_entry_t e,
                                      input logic [ENTRY_AW-1:0] zero_reg);
    return e.valid && e.regwrite && (e.aw != zero_reg);
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Per-read-port match against the EXE/MEM/WB entries; WB participates only
// when FORWARD_HAZARD_WB_FWD_EN is defined.
module fwd_port_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 31
) (
  input  stage_entry_t          exe_i,
  input  stage_entry_t          mem_i,
  input  stage_entry_t          wb_i,
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  logic                  en_i,
  output fwd_sel_t              sel_o,
  output logic                  load_hit_o
);

  localparam logic [ENTRY_AW-1:0] ZERO_EXT = ENTRY_AW'(ZERO_REG);

  logic [ENTRY_AW-1:0] addr_ext;
  logic                port_act;
  logic                hit_exe;
  logic                hit_mem;

  assign addr_ext = ENTRY_AW'(addr_i);
  assign port_act = en_i && (addr_ext != ZERO_EXT);
  assign hit_exe  = port_act && entry_live(exe_i, ZERO_EXT) && (exe_i.aw == addr_ext);
  assign hit_mem  = port_act && entry_live(mem_i, ZERO_EXT) && (mem_i.aw == addr_ext);

`ifdef FORWARD_HAZARD_WB_FWD_EN
  logic hit_wb;
  assign hit_wb = port_act && entry_live(wb_i, ZERO_EXT) && (wb_i.aw == addr_ext);

  always_comb begin
    sel_o = FWD_RF;
    if (hit_exe)      sel_o = FWD_EXE;
    else if (hit_mem) sel_o = FWD_MEM;
    else if (hit_wb)  sel_o = FWD_WB;
  end
`else
  // WB is tracked upstream but never matched in this build.
  logic unused_wb;
  assign unused_wb = ^wb_i;

  always_comb begin
    sel_o = FWD_RF;
    if (hit_exe)      sel_o = FWD_EXE;
    else if (hit_mem) sel_o = FWD_MEM;
  end
`endif

  assign load_hit_o = hit_exe && exe_i.is_load;

endmodule

// File: rtl/forward_hazard_unit.sv
// Decode-side forwarding selects, load-use stall and hazard counter with
// internal EXE/MEM/WB destination tracking. Optional: FORWARD_HAZARD_WB_FWD_EN.
module forward_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_READ_PORTS = 2,
  parameter int REG_ADDR_W     = 5,
  parameter int ZERO_REG       = 31,
  parameter int CNT_W          = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] rd_addr,
  input  logic [NUM_READ_PORTS-1:0]          rd_en,
  input  logic                               dec_valid,
  input  logic [REG_ADDR_W-1:0]              dec_aw,
  input  logic                               dec_regwrite,
  input  logic                               dec_is_load,
  input  logic                               flush,
  output logic [2*NUM_READ_PORTS-1:0]        fwd_sel,
  output logic                               stall,
  output logic [CNT_W-1:0]                   hazard_cnt
);

  stage_entry_t exe_q, exe_d;
  stage_entry_t mem_q, mem_d;
  stage_entry_t wb_q, wb_d;
  stage_entry_t dec_entry;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fwd_sel_t                port_sel [NUM_READ_PORTS];
  logic [NUM_READ_PORTS-1:0] load_hit;

  for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_port
    fwd_port_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .ZERO_REG   (ZERO_REG)
    ) u_match (
      .exe_i      (exe_q),
      .mem_i      (mem_q),
      .wb_i       (wb_q),
      .addr_i     (rd_addr[gi*REG_ADDR_W +: REG_ADDR_W]),
      .en_i       (rd_en[gi]),
      .sel_o      (port_sel[gi]),
      .load_hit_o (load_hit[gi])
    );
  end

  assign stall = dec_valid && !flush && (|load_hit);

  // A stalled decode reads nothing useful, so its operand muxes park on the RF.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      fwd_sel[2*i +: 2] = stall ? FWD_RF : port_sel[i];
    end
  end

  always_comb begin
    dec_entry = '{valid:    dec_valid,
                  aw:       ENTRY_AW'(dec_aw),
                  regwrite: dec_regwrite,
                  is_load:  dec_is_load};
  end

  // Flush kills decode and EXE; a stall only injects a bubble behind the load.
  always_comb begin
    wb_d  = mem_q;
    mem_d = exe_q;
    exe_d = dec_entry;
    cnt_d = cnt_q;
    if (flush) begin
      mem_d = BUBBLE;
      exe_d = BUBBLE;
    end else if (stall) begin
      exe_d = BUBBLE;
    end
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exe_q <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
      cnt_q <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign hazard_cnt = cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed checks of forwarding priority, load-use stall, flush, counter
// saturation (CNT_W = 4) and asynchronous reset.
module tb_forward_hazard_unit;

  localparam int NP = 2;
  localparam int AW = 5;
  localparam int CW = 4;

`ifdef FORWARD_HAZARD_WB_FWD_EN
  localparam logic [1:0] WB_EXP = 2'b11;
`else
  localparam logic [1:0] WB_EXP = 2'b10;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NP*AW-1:0]   rd_addr;
  logic [NP-1:0]      rd_en;
  logic               dec_valid;
  logic [AW-1:0]      dec_aw;
  logic               dec_regwrite;
  logic               dec_is_load;
  logic               flush;
  logic [2*NP-1:0]    fwd_sel;
  logic               stall;
  logic [CW-1:0]      hazard_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  forward_hazard_unit #(
    .NUM_READ_PORTS (NP),
    .REG_ADDR_W     (AW),
    .ZERO_REG       (31),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_addr      (rd_addr),
    .rd_en        (rd_en),
    .dec_valid    (dec_valid),
    .dec_aw       (dec_aw),
    .dec_regwrite (dec_regwrite),
    .dec_is_load  (dec_is_load),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .hazard_cnt   (hazard_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [AW-1:0] aw, input logic rw, input logic ld);
    dec_valid    = v;
    dec_aw       = aw;
    dec_regwrite = rw;
    dec_is_load  = ld;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic e0,
                        input logic [AW-1:0] a1, input logic e1);
    rd_addr = {a1, a0};
    rd_en   = {e1, e0};
  endtask

  task automatic drain();
    set_dec(1'b0, 5'd0, 1'b0, 1'b0);
    set_rd(5'd0, 1'b0, 5'd0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int cyc;

    reset_n = 1'b0;
    flush   = 1'b0;
    set_dec(1'b0, 5'd0, 1'b0, 1'b0);
    set_rd(5'd1, 1'b1, 5'd2, 1'b1);
    #12;
    check("rst_stall", stall, 1'b0);
    check("rst_fwd", fwd_sel, 4'b1010);
    check("rst_cnt", hazard_cnt, 4'd0);
    reset_n = 1'b1;
    tick();

    // ADD X1, then reads of X1 as it ages through EXE, MEM, WB
    set_dec(1'b1, 5'd1, 1'b1, 1'b0);
    set_rd(5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    set_dec(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd1, 1'b1, 5'd0, 1'b0);
    #1;
    check("x1_exe", fwd_sel[1:0], 2'b00);
    check("x1_exe_stall", stall, 1'b0);
    tick();
    check("x1_mem", fwd_sel[1:0], 2'b01);
    tick();
    check("x1_wb", fwd_sel[1:0], WB_EXP);
    tick();
    check("x1_rf", fwd_sel[1:0], 2'b10);
    drain();

    // X1 in both EXE and MEM: EXE wins
    set_dec(1'b1, 5'd1, 1'b1, 1'b0);
    tick();
    tick();
    set_dec(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd5, 1'b1, 5'd1, 1'b1);
    #1;
    check("exe_prio", fwd_sel, 4'b0010);
    drain();

    // LDUR X2 then read of X2: one stall cycle, then MEM forward
    set_dec(1'b1, 5'd2, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd2, 1'b1, 5'd0, 1'b0);
    #1;
    check("lu_stall", stall, 1'b1);
    check("lu_fwd", fwd_sel, 4'b1010);
    check("lu_cnt0", hazard_cnt, 4'd0);
    tick();
    check("lu_stall_end", stall, 1'b0);
    check("lu_mem", fwd_sel[1:0], 2'b01);
    check("lu_cnt1", hazard_cnt, 4'd1);
    drain();

    // Loads to X31 never forward or stall
    set_dec(1'b1, 5'd31, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd31, 1'b1, 5'd31, 1'b1);
    #1;
    check("xzr_stall", stall, 1'b0);
    check("xzr_fwd", fwd_sel, 4'b1010);
    drain();

    // Disabled ports never match
    set_dec(1'b1, 5'd4, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd4, 1'b0, 5'd4, 1'b0);
    #1;
    check("noen_stall", stall, 1'b0);
    check("noen_fwd", fwd_sel, 4'b1010);
    drain();

    // Flush with a load-use pending: no stall, EXE/MEM bubbled
    set_dec(1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    set_dec(1'b1, 5'd3, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd3, 1'b1, 5'd0, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_stall", stall, 1'b0);
    check("fl_fwd", fwd_sel[1:0], 2'b00);
    tick();
    flush = 1'b0;
    #1;
    check("fl_after", fwd_sel[1:0], WB_EXP);
    tick();
    check("fl_after2", fwd_sel[1:0], 2'b10);
    check("fl_cnt", hazard_cnt, 4'd1);
    drain();

    // LDUR X2,[X2] repeatedly: stalls every other cycle, counter saturates
    set_dec(1'b1, 5'd2, 1'b1, 1'b1);
    set_rd(5'd2, 1'b1, 5'd0, 1'b0);
    stalls = 0;
    cyc    = 0;
    while (stalls < 20 && cyc < 100) begin
      #1;
      if (stall) stalls++;
      tick();
      cyc++;
    end
    check("sat_stalls", stalls, 20);
    check("sat_cnt", hazard_cnt, 4'd15);
    tick();
    check("pre_rst_stall", stall, 1'b1);

    reset_n = 1'b0;
    #1;
    check("mid_rst_cnt", hazard_cnt, 4'd0);
    check("mid_rst_fwd", fwd_sel, 4'b1010);
    check("mid_rst_stall", stall, 1'b0);
    #1;
    reset_n = 1'b1;
    set_dec(1'b1, 5'd0, 1'b0, 1'b0);
    set_rd(5'd2, 1'b1, 5'd2, 1'b1);
    #1;
    check("post_rst_fwd", fwd_sel, 4'b1010);
    tick();
    check("post_rst_fwd2", fwd_sel, 4'b1010);
    check("post_rst_cnt", hazard_cnt, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Parametrised successor to the two-port EXE/MEM forwarding unit: tracks destination-register state of the in-flight instructions internally, rather than taking it from pipeline registers, through EXE, MEM and optionally WB shadow stages. Produces per-read-port forwarding selects for N read ports, detects load-use hazards, and generates a one-cycle stall with bubble insertion. Accepts branch flushes and keeps a saturating hazard counter. Sits beside the decode stage of the 5-stage ARM pipeline, driving operand muxes and the PC/IF-ID stall.

## Interface
- NUM_READ_PORTS, 2: number of decode-stage source-register ports.
- REG_ADDR_W, 5: register address width.
- ZERO_REG, 31: register never forwarded (XZR); matches never hit.
- CNT_W, 16: hazard counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_READ_PORTS*REG_ADDR_W  decode source addresses, port i at bits [i*REG_ADDR_W +: REG_ADDR_W].
- rd_en  in  NUM_READ_PORTS  port i actually reads; 0 means no match and no stall.
- dec_valid  in  1  decode holds a real instruction.
- dec_aw  in  REG_ADDR_W  decode destination register.
- dec_regwrite  in  1  decode instruction writes dec_aw.
- dec_is_load  in  1  decode instruction is LDUR.
- flush  in  1  kill the instructions currently in decode and EXE.
- fwd_sel  out  2*NUM_READ_PORTS  per-port select: 00 EXE, 01 MEM, 10 register file, 11 WB.
- stall  out  1  hold PC and IF/ID this cycle.
- hazard_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Three tracking entries EXE, MEM and WB, each holding {valid, aw, regwrite, is_load}. An entry is *live* when valid & regwrite & aw != ZERO_REG.
- Per port i with rd_en[i] = 1, priority order:
  - live EXE entry with matching aw: 00.
  - otherwise live MEM entry with matching aw: 01.
  - otherwise live WB entry with matching aw: 11 (FWD_WB_EN only).
  - otherwise: 10.
- A port with rd_en[i] = 0 or rd_addr == ZERO_REG always selects 10.
- Load-use: stall = dec_valid & ~flush & (any enabled port matches a live EXE entry with is_load = 1). While stall = 1, every fwd_sel field is forced to 10.
- Edge update, no stall or flush: WB←MEM, MEM←EXE, EXE←{dec_valid, dec_aw, dec_regwrite, dec_is_load}.
- Edge update, stall: WB←MEM, MEM←EXE, EXE←bubble (valid = 0). The decode instruction is re-presented on the next cycle.
- Edge update, flush: WB←MEM, MEM←bubble, EXE←bubble. Flush overrides stall, and stall reads 0 during flush.
- hazard_cnt increments on each edge where stall = 1 and holds at all-ones (saturates, no wrap).

## Timing
- fwd_sel and stall are combinational from the current entries and inputs; zero latency.
- Entries update on the rising clk edge. An instruction is visible as EXE one cycle after it is accepted in decode, MEM after two cycles, WB after three.
- A load-use stall lasts exactly one cycle. On the following cycle the load is in MEM and the same port selects 01.
- Reset, asynchronous on reset_n low:
  - all entries invalid; hazard_cnt = 0.
  - stall = 0 and every fwd_sel = 10 until the first live entry exists.
- reset_n deasserted mid-stream: the pipeline state is discarded and no forwarding occurs from pre-reset instructions.

## Configuration
- FORWARD_HAZARD_WB_FWD_EN defined: the WB entry participates in matching, and select 11 is used.
- Not defined:
  - the WB entry is still tracked but never matched.
  - select 11 is never produced.
  - the register file must write before it is read.

## Structure
- Package hazard_pkg holds:
  - enum fwd_sel_t: FWD_EXE = 2'b00, FWD_MEM = 2'b01, FWD_RF = 2'b10, FWD_WB = 2'b11.
  - struct stage_entry_t {valid, aw, regwrite, is_load}.
  - localparam XZR = 5'd31.
- Sub-module fwd_port_match: one instance per read port, generated. Takes the three entries plus one port's address and enable; returns fwd_sel_t and a load_hit bit.
- The top level owns the entry registers, the stall OR-reduction and the counter.

## Test plan
- ADD X1 write, then next-cycle read of X1 on port 0 → fwd_sel[1:0] = 00. One cycle later with no new writer → 01. One more cycle → 11 with the macro, 10 without.
- X1 written in both EXE and MEM, port 1 reads X1 → 00 (EXE priority).
- LDUR X2 followed by a read of X2 → stall = 1 for one cycle, fwd_sel = 10, hazard_cnt 0→1. Next cycle → stall = 0, select 01.
- Writer to X31, then read X31 → select 10, no stall. rd_en = 0 on a matching address → 10, no stall.
- LDUR X3 in EXE, read of X3 with flush = 1 in the same cycle → stall = 0. After the edge, EXE and MEM are invalid, and a read of X3 → 10.
- Hold the load-use pattern with CNT_W = 4 for 20 stall cycles → hazard_cnt = 15. Assert reset_n = 0 mid-run → counter 0, all selects 10 immediately.
